lisnoc_output_vc_fifo: RTL

//  Per-virtual-channel flit buffer at a router output port, directly upstream of the output arbiter.

---
 rtl/lisnoc_output_vc_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/lisnoc_output_vc_fifo.sv
// lisnoc_output_vc_fifo: one circular flit FIFO per virtual channel, feeding the output arbiter.
// Optional feature: define LISNOC_OUTFIFO_BYPASS_EN for same-cycle pass-through into an empty VC.
module lisnoc_output_vc_fifo #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 1,
  parameter int fifo_length     = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [flit_data_width+flit_type_width-1:0]            in_flit_i,
  input  logic [vchannels-1:0]                                  in_valid_i,
  output logic [vchannels-1:0]                                  in_ready_o,
  output logic [vchannels*(flit_data_width+flit_type_width)-1:0] fifo_flit_o,
  output logic [vchannels-1:0]                                  fifo_valid_o,
  input  logic [vchannels-1:0]                                  fifo_ready_i
);

  localparam int flit_width  = flit_data_width + flit_type_width;
  localparam int ptr_width   = $clog2(fifo_length);
  localparam int count_width = $clog2(fifo_length + 1);

  localparam logic [ptr_width-1:0]   last_ptr   = ptr_width'(fifo_length - 1);
  localparam logic [ptr_width-1:0]   ptr_one    = ptr_width'(1);
  localparam logic [count_width-1:0] full_count = count_width'(fifo_length);
  localparam logic [count_width-1:0] count_one  = count_width'(1);

  // Explicit wrap compare so non-power-of-two depths work.
  function automatic logic [ptr_width-1:0] ptr_next(input logic [ptr_width-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_one;
  endfunction

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    logic [flit_width-1:0]  storage [fifo_length];
    logic [ptr_width-1:0]   wr_ptr;
    logic [ptr_width-1:0]   rd_ptr;
    logic [count_width-1:0] count;
    logic                   stored;
    logic                   push;
    logic                   pop;

    assign stored = (count != '0);

    // Ready comes only from the registered count and is forced low during reset.
    assign in_ready_o[v] = rst & (count < full_count);
    assign pop           = stored & fifo_ready_i[v];

`ifdef LISNOC_OUTFIFO_BYPASS_EN
    logic bypass_take;

    assign bypass_take     = rst & ~stored & in_valid_i[v];
    assign fifo_valid_o[v] = stored | bypass_take;
    assign fifo_flit_o[v*flit_width +: flit_width] = stored ? storage[rd_ptr] : in_flit_i;
    assign push = in_valid_i[v] & in_ready_o[v] & ~(bypass_take & fifo_ready_i[v]);
`else
    assign fifo_valid_o[v] = stored;
    assign fifo_flit_o[v*flit_width +: flit_width] = storage[rd_ptr];
    assign push = in_valid_i[v] & in_ready_o[v];
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + count_one;
          2'b01:   count <= count - count_one;
          default: count <= count;
        endcase
      end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
      if (push) storage[wr_ptr] <= in_flit_i;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) $onehot0(in_valid_i));

endmodule
